// File: rtl/hamming_pkg.sv
// ============================================================================
// hamming_pkg : Hamming(7,4) position map, flit layout, encode/syndrome helpers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int HDR_W  = 4;
  localparam int PLD_W  = 4;
  localparam int FLIT_W = CW_W + HDR_W;

  // Codeword index i holds Hamming position i+1; parity sits at powers of two.
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef struct packed {
    logic [CW_W-1:0]  cw;
    logic [HDR_W-1:0] hdr;
  } flit_t;

  function automatic logic [CW_W-1:0] hamming_encode(input logic [PLD_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw         = '0;
    cw[D0_IDX] = d[0];
    cw[D1_IDX] = d[1];
    cw[D2_IDX] = d[2];
    cw[D3_IDX] = d[3];
    cw[P1_IDX] = d[0] ^ d[1] ^ d[3];
    cw[P2_IDX] = d[0] ^ d[2] ^ d[3];
    cw[P4_IDX] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

  // Non-zero result is the 1-based position of a single flipped bit.
  function automatic logic [2:0] hamming_syndrome(input logic [CW_W-1:0] cw);
    logic [2:0] s;
    s[0] = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
    s[1] = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
    s[2] = cw[P4_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_fifo.sv
// ============================================================================
// hamming_fifo : DEPTH-entry valid/ready FIFO, registered ready, last-value hold
// Revision     : 1.0
// ============================================================================
`default_nettype none

module hamming_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] c_depth    = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == c_ptr_last) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on stored occupancy, so a pop never frees a slot the same cycle.
  assign o_push_ready = (r_occ < c_depth);
  assign o_pop_valid  = (r_occ != '0);
  assign o_pop_data   = o_pop_valid ? r_mem[r_rptr] : r_last;
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = o_pop_valid & i_pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= f_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
        r_last <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_ecu_tx.sv
// ============================================================================
// hamming_ecu_tx : Hamming(7,4) flit encoder with fault injection and counters
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hamming_ecu_tx #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] inj_count
);

  import hamming_pkg::*;

  logic [CW_W-1:0]  w_cw_clean;
  logic [CW_W-1:0]  w_inj_mask;
  logic             w_inj;
  flit_t            w_flit;
  logic [FLIT_W:0]  w_entry;
  logic [FLIT_W:0]  w_head;
  logic [CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0] r_inj_count;

  always_comb begin
    w_cw_clean = hamming_encode(in_data[7:4]);
    w_inj      = (inj_pos != 3'd0);
    w_inj_mask = w_inj ? (CW_W'(1) << (inj_pos - 3'd1)) : '0;
    w_flit.cw  = w_cw_clean ^ w_inj_mask;
    w_flit.hdr = in_data[3:0];
    w_entry    = {w_flit, w_inj};
  end

  hamming_fifo #(
    .WIDTH (FLIT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_entry),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_head)
  );

  assign out_data  = w_head[FLIT_W:1];
  assign pkt_count = r_pkt_count;
  assign inj_count = r_inj_count;

  // Counters track delivered flits, so they step on the output handshake only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
      r_inj_count <= '0;
    end else if (out_valid && out_ready) begin
      r_pkt_count <= r_pkt_count + CNT_W'(1);
      if (w_head[0]) begin
        r_inj_count <= r_inj_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_ecu_tx.sv
// ============================================================================
// tb_hamming_ecu_tx : randomized + directed bench against a position-based model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_hamming_ecu_tx;
  import hamming_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MASK = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic [2:0]          inj_pos;
  logic                out_valid;
  logic                out_ready;
  logic [10:0]         out_data;
  logic [TB_CNT_W-1:0] pkt_count;
  logic [TB_CNT_W-1:0] inj_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] q[$];
  int          exp_pkt = 0;
  int          exp_inj = 0;
  logic [10:0] last_out = '0;

  hamming_ecu_tx #(
    .DEPTH (2),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pkt_count (pkt_count),
    .inj_count (inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: build positions 1..7, data at non-powers of two, each parity
  // position p is the XOR of data positions whose index has bit p set.
  function automatic logic [10:0] model_flit(input logic [3:0] d, input logic [3:0] h,
                                             input int ip);
    logic [7:0] pos;
    int dpos[4];
    int par[3];
    dpos = '{3, 5, 6, 7};
    par  = '{1, 2, 4};
    pos  = '0;
    for (int k = 0; k < 4; k++) pos[dpos[k]] = d[k];
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 4; k++)
        if ((dpos[k] & par[a]) != 0) pos[par[a]] = pos[par[a]] ^ pos[dpos[k]];
    if (ip != 0) pos[ip] = ~pos[ip];
    return {pos[7:1], h};
  endfunction

  // Called just after a falling edge; returns at falling edge + 1.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] ip,
                      input logic rdy, output logic acc);
    logic        pop;
    logic [11:0] head;
    in_valid  = v;
    in_data   = d;
    inj_pos   = ip;
    out_ready = rdy;
    #1;
    chk("out_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      head = q[0];
      chk("out_data", out_data, head[11:1]);
    end else begin
      chk("out_data_hold", out_data, last_out);
    end
    chk("in_ready", in_ready, (q.size() < 2));
    chk("pkt_count", pkt_count, exp_pkt & CNT_MASK);
    chk("inj_count", inj_count, exp_inj & CNT_MASK);
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && rdy;
    @(posedge clk);
    if (pop) begin
      head     = q.pop_front();
      last_out = head[11:1];
      exp_pkt++;
      if (head[0]) exp_inj++;
    end
    if (acc) q.push_back({model_flit(d[7:4], d[3:0], int'(ip)), (ip != 3'd0)});
    @(negedge clk);
    #1;
  endtask

  task automatic send_chk(input logic [3:0] pl, input logic [3:0] hd, input logic [2:0] ip,
                          input logic [10:0] exp_flit);
    logic acc;
    step(1'b1, {pl, hd}, ip, 1'b1, acc);
    chk("dir_flit", out_data, exp_flit);
    chk("syndrome", hamming_syndrome(out_data[10:4]), ip);
    step(1'b0, 8'h00, 3'd0, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_pkt  = 0;
    exp_inj  = 0;
    last_out = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [10:0] flip;
    int          tries;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    inj_pos   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_inj", inj_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    send_chk(4'hB, 4'h5, 3'd0, 11'h555);
    chk("pkt_after_first", pkt_count, 1);
    send_chk(4'hF, 4'hA, 3'd0, 11'h7FA);
    send_chk(4'h0, 4'h3, 3'd0, 11'h003);
    send_chk(4'hB, 4'h5, 3'd3, 11'h515);
    chk("inj_after_first", inj_count, 1);

    for (int p = 0; p < 16; p++)
      send_chk(4'(p), 4'(15 - p), 3'd0, model_flit(4'(p), 4'(15 - p), 0));

    for (int ip = 1; ip < 8; ip++) begin
      step(1'b1, 8'hB5, 3'(ip), 1'b1, acc);
      flip = out_data ^ 11'h555;
      chk("inj_flit", out_data, 11'h555 ^ (11'd1 << (ip + 3)));
      chk("inj_onebit", $countones(flip), 1);
      chk("inj_syndrome", hamming_syndrome(out_data[10:4]), ip);
      step(1'b0, 8'h00, 3'd0, 1'b1, acc);
    end

    // Back-pressure: three packets with the router stalled.
    step(1'b1, 8'h11, 3'd0, 1'b0, acc);
    step(1'b1, 8'h22, 3'd0, 1'b0, acc);
    step(1'b1, 8'h33, 3'd0, 1'b0, acc);
    chk("bp_third_held", in_ready, 0);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      step(1'b1, 8'h33, 3'd0, 1'b1, acc);
      tries++;
    end
    chk("bp_third_accepted", acc, 1);
    repeat (4) step(1'b0, 8'h00, 3'd0, 1'b1, acc);
    chk("bp_drained", out_valid, 0);

    // Streaming: 20 packets from a clean counter state.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 3'd0, 1'b1, acc);
      if (i > 0) chk("stream_valid", out_valid, 1);
    end
    step(1'b0, 8'h00, 3'd0, 1'b1, acc);
    chk("stream_pkt_wrap", pkt_count, 4);

    // Reset with two entries parked behind a stalled router.
    step(1'b1, 8'h9C, 3'd2, 1'b0, acc);
    step(1'b1, 8'h4E, 3'd0, 1'b0, acc);
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_pkt", pkt_count, 0);
    chk("mid_rst_inj", inj_count, 0);
    chk("mid_rst_data", out_data, 0);
    q.delete();
    exp_pkt  = 0;
    exp_inj  = 0;
    last_out = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00, 3'd0, 1'b1, acc);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
           ($urandom_range(0, 3) != 0), acc);
    end
    repeat (4) step(1'b0, 8'h00, 3'd0, 1'b1, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
